// File: rtl/serial_rx_pkg.sv
// Shared types and default sizing for the serial byte receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Serial input stream plus word-output handshake of the serial byte receiver.
interface serial_byte_receiver_if
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             sin_valid;
  logic             sin_data;
  logic             sin_first;
  logic             sin_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_rev;
  logic             frame_err;

  modport master (
    output sin_valid, sin_data, sin_first, out_ready,
    input  sin_ready, out_valid, out_data, out_rev, frame_err
  );

  modport slave (
    input  sin_valid, sin_data, sin_first, out_ready,
    output sin_ready, out_valid, out_data, out_rev, frame_err
  );
endinterface

// File: rtl/bit_reverser.sv
// Combinational bit reversal: out[WIDTH-1-i] = in[i]. Zero latency, no flow control.
module bit_reverser #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out[WIDTH-1-i] = in[i];
    end
  end
endmodule

// File: rtl/serial_byte_receiver.sv
// LSB-first serial-to-word assembler with one-word output buffer; word valid the cycle after its last bit.
// sin_ready drops only while a completed word waits behind a full buffer (HOLD).
module serial_byte_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_byte_receiver_if.slave bus
);
  localparam int CNT_W  = $clog2(WIDTH);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   out_dat_q, out_dat_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   word;
  logic               accept;
  logic               drain;

  assign bus.sin_ready = (state_q != ST_HOLD);
  assign accept        = bus.sin_valid && bus.sin_ready;
  assign drain         = out_vld_q && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    shift_d   = shift_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    err_d     = 1'b0;
    word          = shift_q;
    word[cnt_q]   = bus.sin_data;

    if (drain) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && bus.sin_first) begin
          shift_d = {{(WIDTH-1){1'b0}}, bus.sin_data};
          cnt_d   = CNT_W'(1);
          idle_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          idle_d = '0;
          if (bus.sin_first) begin
            err_d   = 1'b1;
            shift_d = {{(WIDTH-1){1'b0}}, bus.sin_data};
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            shift_d = word;
            cnt_d   = '0;
            // A buffer draining on this same edge counts as empty.
            if (!out_vld_q || drain) begin
              out_vld_d = 1'b1;
              out_dat_d = word;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          idle_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_HOLD: begin
        if (drain) begin
          out_vld_d = 1'b1;
          out_dat_d = shift_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idle_q    <= '0;
      shift_q   <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      shift_q   <= shift_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      err_q     <= err_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.frame_err = err_q;

  bit_reverser #(.WIDTH(WIDTH)) u_rev (
    .in  (out_dat_q),
    .out (bus.out_rev)
  );
endmodule

// File: tb/tb_serial_byte_receiver.sv
// Randomised and directed bench for serial_byte_receiver with a transaction-level scoreboard.
module tb_serial_byte_receiver;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   got_words;
  int   err_pulses;
  bit   rand_on;
  logic [W-1:0] exp_q[$];

  serial_byte_receiver_if #(.WIDTH(W)) bus ();

  serial_byte_receiver #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Scoreboard: every handshake must match the oldest completed word.
  initial begin : monitor
    logic         prev_stall;
    logic [W-1:0] prev_dat;
    logic [W-1:0] e;
    prev_stall = 1'b0;
    prev_dat   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.frame_err === 1'b1) err_pulses++;
        if (bus.out_valid === 1'b1) begin
          n_vec++;
          if (bus.out_rev !== rev(bus.out_data)) begin
            n_err++;
            $display("FAIL out_rev: got %h expected %h", bus.out_rev, rev(bus.out_data));
          end
        end
        if (prev_stall) begin
          n_vec++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== prev_dat) begin
            n_err++;
            $display("FAIL stall_stable: got vld=%b dat=%h expected vld=1 dat=%h",
                     bus.out_valid, bus.out_data, prev_dat);
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          got_words++;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin
              n_err++;
              $display("FAIL word_order: got %h expected %h", bus.out_data, e);
            end
          end
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        prev_dat   = bus.out_data;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic d, input logic f);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    bus.sin_valid = 1'b1;
    bus.sin_data  = d;
    bus.sin_first = f;
    while (!done && t < 200) begin
      done = (bus.sin_ready === 1'b1);
      @(posedge clk);
      #1;
      t++;
    end
    bus.sin_valid = 1'b0;
    bus.sin_first = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL send_bit_timeout: got sin_ready=%b expected 1 within 200 cycles", bus.sin_ready);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int max_gap);
    for (int i = 0; i < W; i++) begin
      if (max_gap > 0) cyc($urandom_range(0, max_gap));
      send_bit(w[i], i == 0);
    end
    exp_q.push_back(w);
  endtask

  task automatic test_reset;
    cyc(2);
    n_vec += 5;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_data !== '0)    begin n_err++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
    if (bus.out_rev !== '0)     begin n_err++; $display("FAIL rst_out_rev: got %h expected 00", bus.out_rev); end
    if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b expected 0", bus.frame_err); end
    if (bus.sin_ready !== 1'b1) begin n_err++; $display("FAIL rst_sin_ready: got %b expected 1", bus.sin_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    logic [W-1:0] bits;
    bits = 8'b1000_1101;
    bus.out_ready = 1'b1;
    for (int i = 0; i < W; i++) send_bit(bits[i], i == 0);
    exp_q.push_back(bits);
    n_vec += 3;
    if (bus.out_valid !== 1'b1)       begin n_err++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    if (bus.out_data !== 8'b1000_1101) begin n_err++; $display("FAIL basic_data: got %b expected 10001101", bus.out_data); end
    if (bus.out_rev !== 8'b1011_0001)  begin n_err++; $display("FAIL basic_rev: got %b expected 10110001", bus.out_rev); end
    cyc(1);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    n_vec += 2;
    if (bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready: got %b expected 0", bus.sin_ready); end
    if (bus.out_data !== 8'hA5) begin n_err++; $display("FAIL bp_held_data: got %h expected a5", bus.out_data); end
    cyc(3);
    n_vec += 2;
    if (bus.sin_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_hold: got %b expected 0", bus.sin_ready); end
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_still_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    cyc(1);
    n_vec += 3;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %b expected 1", bus.out_valid); end
    if (bus.out_data !== 8'h3C) begin n_err++; $display("FAIL bp_second_data: got %h expected 3c", bus.out_data); end
    if (bus.sin_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b expected 1", bus.sin_ready); end
    cyc(1);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_restart;
    int e0;
    e0 = err_pulses;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), i == 0);
    send_bit(1'b1, 1'b1);
    n_vec++;
    if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL restart_pulse: got %b expected 1", bus.frame_err); end
    for (int i = 1; i < W; i++) send_bit(1'b1, 1'b0);
    exp_q.push_back(8'hFF);
    cyc(3);
    n_vec += 2;
    if (err_pulses - e0 != 1) begin n_err++; $display("FAIL restart_err_count: got %0d expected 1", err_pulses - e0); end
    if (exp_q.size() != 0)    begin n_err++; $display("FAIL restart_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    int e0;
    int g0;
    logic [W-1:0] w;
    e0 = err_pulses;
    g0 = got_words;
    bus.out_ready = 1'b1;
    w = W'($urandom);
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
    for (int k = 1; k < TO; k++) begin
      cyc(1);
      n_vec++;
      if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL timeout_early: idle %0d got %b expected 0", k, bus.frame_err); end
    end
    cyc(1);
    n_vec++;
    if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL timeout_pulse: got %b expected 1", bus.frame_err); end
    cyc(1);
    n_vec += 3;
    if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL timeout_width: got %b expected 0", bus.frame_err); end
    if (got_words != g0)        begin n_err++; $display("FAIL timeout_no_word: got %0d expected %0d", got_words, g0); end
    if (err_pulses - e0 != 1)   begin n_err++; $display("FAIL timeout_err_count: got %0d expected 1", err_pulses - e0); end
    send_word(8'h5A, 0);
    cyc(3);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL timeout_next_word: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe;
    logic [W-1:0] w;
    bus.out_ready = 1'b0;
    send_word(8'hC3, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), i == 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_vec += 3;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    if (bus.sin_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", bus.sin_ready); end
    if (bus.out_data !== '0)    begin n_err++; $display("FAIL midrst_data: got %h expected 00", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    bus.out_ready = 1'b1;
    w = W'($urandom);
    send_word(w, 0);
    cyc(3);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_next_word: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_stray;
    int e0;
    int g0;
    e0 = err_pulses;
    g0 = got_words;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    cyc(3);
    n_vec += 2;
    if (got_words != g0)  begin n_err++; $display("FAIL stray_word: got %0d expected %0d", got_words, g0); end
    if (err_pulses != e0) begin n_err++; $display("FAIL stray_err: got %0d expected %0d", err_pulses, e0); end
  endtask

  task automatic test_random;
    int e0;
    int exp_err;
    int t;
    e0      = err_pulses;
    exp_err = 0;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 5) == 0) send_bit(1'($urandom_range(0, 1)), 1'b0);
      cyc($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(1, W - 1);
        for (int i = 0; i < k; i++) begin
          cyc($urandom_range(0, 3));
          send_bit(1'($urandom_range(0, 1)), i == 0);
        end
        exp_err++;
        cyc($urandom_range(0, 3));
      end
      send_word(W'($urandom), 3);
    end
    rand_on = 1'b0;
    cyc(2);
    bus.out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      cyc(1);
      t++;
    end
    cyc(2);
    n_vec += 2;
    if (exp_q.size() != 0)          begin n_err++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
    if (err_pulses - e0 != exp_err) begin n_err++; $display("FAIL rand_err_count: got %0d expected %0d", err_pulses - e0, exp_err); end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    got_words     = 0;
    err_pulses    = 0;
    rand_on       = 1'b0;
    rst_n         = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
    bus.sin_first = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_restart();
    test_timeout();
    test_reset_midframe();
    test_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Receives a 1-bit serial stream from an upstream serializer, LSB first with a frame-start marker, and reassembles `WIDTH`-bit words. Each completed word is presented with a valid/ready handshake in two forms: as received, and bit-reversed. It sits at the receiving end of the serial byte link, ahead of the bit-reversal consumers. It has a one-word output buffer, per-bit backpressure and an idle-timeout abort.

## Interface
- `WIDTH`, default 8: word width in bits, must be ≥2.
- `TIMEOUT`, default 16: number of consecutive mid-frame cycles without an accepted bit before the frame is aborted, must be ≥1.

- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sin_valid` in 1: serial bit present.
- `sin_data` in 1: serial bit value.
- `sin_first` in 1: qualifies the current bit as bit 0 of a new frame.
- `sin_ready` out 1: a bit is accepted on an edge where `sin_valid && sin_ready`.
- `out_valid` out 1: the output word is held.
- `out_ready` in 1: the consumer takes the word on an edge where `out_valid && out_ready`.
- `out_data` out `WIDTH`: assembled word, first-received bit at `out_data[0]`.
- `out_rev` out `WIDTH`: bit reverse of `out_data`, so `out_rev[WIDTH-1-i] = out_data[i]`.
- `frame_err` out 1: one-cycle pulse on abort or restart.

## Operation
- The FSM has three states: IDLE, SHIFT, HOLD. A bit counter `cnt` runs 0..WIDTH-1 and an idle counter `idle` runs 0..TIMEOUT.
- `sin_ready` = (state != HOLD).
- **IDLE**
  - An accepted bit with `sin_first`=1 goes to shift[0], sets `cnt`=1 and moves to SHIFT.
  - An accepted bit with `sin_first`=0 is dropped silently, with no error.
- **SHIFT**
  - An accepted bit goes to shift[`cnt`], increments `cnt` and clears `idle`.
  - An accepted bit with `sin_first`=1 while in SHIFT pulses `frame_err`, discards the partial word and restarts: this bit becomes bit 0 and `cnt`=1.
  - A cycle with no accepted bit increments `idle`. When `idle` reaches TIMEOUT, the block pulses `frame_err`, discards the partial word and moves to IDLE.
  - When bit WIDTH-1 is accepted, the word is complete:
    - If the output buffer is empty, or is being drained on this same edge, the word loads into the buffer and the state goes to IDLE.
    - Otherwise the word waits in the shift register and the state goes to HOLD.
- **HOLD**
  - On the edge where the buffer drains, the held word loads into the buffer and the state goes to IDLE.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- `out_rev` is derived combinationally from the `out_data` register.
- **Reset values** (also the result of reset mid-operation): state=IDLE, `cnt`=0, `idle`=0, `out_valid`=0, `out_data`=0, `out_rev`=0, `frame_err`=0, `sin_ready`=1. Any partial or held word is lost.

## Timing
- Latency: if the last bit is accepted on edge N, `out_valid`=1 and the new `out_data` appear after edge N, i.e. in cycle N+1.
- Throughput: one bit per cycle and one word every WIDTH cycles with `out_ready` held at 1. There are no bubbles, including a `sin_first` arriving on the cycle right after the last bit.
- Backpressure: `sin_ready` falls in the cycle after the edge that enters HOLD. It rises in the cycle after the draining edge, so exactly one input cycle is lost per HOLD.
- `frame_err` is registered and high for exactly one cycle, the cycle after the triggering edge.
- A timeout abort and a drain on the same edge are independent; both take effect.

## Structure
- Package `serial_rx_pkg` holds the state enum (IDLE/SHIFT/HOLD) and the default `WIDTH`/`TIMEOUT` constants.
- Sub-module `bit_reverser`: parameterised `WIDTH`, purely combinational, maps `in` to `out` as reversed. It is instantiated once on `out_data`.
- The remaining logic is the FSM, the counters, the shift register and the output register, all in one always block set on async-low `rst_n`.

## Test plan
- **Basic word:** `out_ready`=1; send bits 1,0,1,1,0,0,0,1 (first marked) → `out_data`=8'b1000_1101, `out_rev`=8'b1011_0001, `out_valid` for one cycle, one cycle after the 8th bit.
- **Backpressure:** `out_ready`=0; send 2 words of 8'hA5 then 8'h3C → 8'hA5 is held, state=HOLD, `sin_ready`=0. Raise `out_ready` → 8'hA5 then 8'h3C are delivered in order, none lost.
- **Restart:** after 3 bits, send `sin_first`=1 plus 8 bits of 8'hFF → `frame_err` pulses once and only 8'hFF is output.
- **Timeout:** with TIMEOUT=16, send 4 bits then idle 16 cycles → `frame_err` pulses on the 16th idle edge, nothing is output, and a following marked word of 8'h5A is received correctly.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously after 5 bits → `out_valid`=0 and `sin_ready`=1 immediately; the next full word is correct.
- **Stray bits:** 10 bits with `sin_first`=0 while in IDLE → no output and no `frame_err`.
